// File: rtl/boot_loader_pkg.sv
// Shared encodings and constants for the boot loader: FSM states, frame sizing
// and the per-state registered control outputs.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_WRITE   = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef struct packed {
        logic ready;
        logic core_rst;
        logic done;
        logic err;
    } ctrl_t;

    // Control outputs are a pure function of the state being entered, so they
    // can be registered together with the state itself.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '{ready: 1'b0, core_rst: 1'b1, done: 1'b0, err: 1'b0};
        case (s)
            S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHECK: c.ready = 1'b1;
            S_DONE: begin
                c.core_rst = 1'b0;
                c.done     = 1'b1;
            end
            S_ERROR: c.err = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
interface boot_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/boot_loader_word_packer.sv
// Packs accepted payload bytes LSB-first into 32-bit words and pulses word_done
// in the cycle after the fourth byte, while the assembled word is held stable.
module boot_loader_word_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        last,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [31:0] sh;

    assign last = (cnt == 2'(BYTES_PER_WORD - 1));
    assign word = sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sh        <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= push && last;
            if (clr) begin
                cnt <= '0;
            end else if (push) begin
                cnt <= cnt + 2'd1;
            end
            // New bytes enter at the top so the first byte ends up in [7:0].
            if (push) begin
                sh <= {din, sh[31:8]};
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Framed program loader: length header, payload packed into words and written
// to instruction memory, XOR checksum; the core is released only on a good image.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    boot_loader_if.slave bus,
    output logic         core_rst,
    output logic         done,
    output logic         err
);

    localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

    state_t      state;
    ctrl_t       ctrl;
    logic [15:0] len;
    logic [15:0] idx;
    logic [7:0]  csum;
    logic [31:0] wr_addr;
    logic [15:0] hdr_len;
    logic        accept;
    logic        restart;
    logic        pk_push;
    logic        pk_last;
    logic        pk_done;
    logic [31:0] pk_word;

    assign accept  = bus.byte_valid && ctrl.ready;
    assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign pk_push = accept && (state == S_PAYLOAD);
    assign hdr_len = {bus.byte_data, len[7:0]};

    assign bus.byte_ready = ctrl.ready;
    assign bus.wr_en      = pk_done;
    assign bus.wr_data    = pk_word;
    assign bus.wr_addr    = wr_addr;
    assign core_rst       = ctrl.core_rst;
    assign done           = ctrl.done;
    assign err            = ctrl.err;

    boot_loader_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .push      (pk_push),
        .din       (bus.byte_data),
        .last      (pk_last),
        .word_done (pk_done),
        .word      (pk_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ctrl    <= ctrl_of(S_IDLE);
            len     <= '0;
            idx     <= '0;
            csum    <= '0;
            wr_addr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state <= S_LEN_LO;
                        ctrl  <= ctrl_of(S_LEN_LO);
                        len   <= '0;
                        idx   <= '0;
                        csum  <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= bus.byte_data;
                        state    <= S_LEN_HI;
                        ctrl     <= ctrl_of(S_LEN_HI);
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.byte_data;
                        if ({1'b0, hdr_len} > MAX_WORDS) begin
                            state <= S_ERROR;
                            ctrl  <= ctrl_of(S_ERROR);
                        end else if (hdr_len == 16'd0) begin
                            state <= S_CHECK;
                            ctrl  <= ctrl_of(S_CHECK);
                        end else begin
                            state <= S_PAYLOAD;
                            ctrl  <= ctrl_of(S_PAYLOAD);
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        csum <= csum ^ bus.byte_data;
                        if (pk_last) begin
                            wr_addr <= {14'd0, idx, 2'b00};
                            state   <= S_WRITE;
                            ctrl    <= ctrl_of(S_WRITE);
                        end
                    end
                end
                S_WRITE: begin
                    idx <= idx + 16'd1;
                    if (idx + 16'd1 == len) begin
                        state <= S_CHECK;
                        ctrl  <= ctrl_of(S_CHECK);
                    end else begin
                        state <= S_PAYLOAD;
                        ctrl  <= ctrl_of(S_PAYLOAD);
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (bus.byte_data == csum) begin
                            state <= S_DONE;
                            ctrl  <= ctrl_of(S_DONE);
                        end else begin
                            state <= S_ERROR;
                            ctrl  <= ctrl_of(S_ERROR);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctrl  <= ctrl_of(S_IDLE);
                end
            endcase
        end
    end

endmodule
